prog_loader: RTL

Byte-stream program loader that sits directly upstream of the processor's instruction memory. It receives a framed program image one byte at a time, assembles 32-bit big-endian instruction words, and writes them into consecutive word addresses of instruction memory. The core is held in reset until the image has been received and its checksum has been verified. The memory is word-addressed, matching the PC, which advances by 1 per instruction.

---
 rtl/prog_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a length-prefixed, XOR-checksummed image and
// writes big-endian 32-bit words to instruction memory, holding the core in reset until done.
module prog_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                  state_r, state_s;
  logic                    rx_ready_r, imem_we_r, core_reset_r, done_r, error_r;
  logic [ADDR_WIDTH-1:0]   imem_addr_r;
  logic [31:0]             imem_wdata_r;
  logic [15:0]             len_r;
  logic [7:0]              len_hi_r, csum_r;
  logic [23:0]             shift_r;
  logic [1:0]              byte_idx_r;
  logic [15:0]             word_idx_r;
  logic                    xfer_s, restart_s, last_word_s;
  logic [16:0]             len_full_s;

  // rx_ready_r mirrors the receiving states, so it doubles as the handshake qualifier
  assign xfer_s      = rx_valid & rx_ready_r;
  assign restart_s   = start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR));
  assign len_full_s  = {1'b0, len_hi_r, rx_data};
  assign last_word_s = (byte_idx_r == 2'd3) & (word_idx_r == len_r - 16'd1);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (start) state_s = LEN_HI;
        else       state_s = state_r;
      end
      LEN_HI: begin
        if (xfer_s) state_s = LEN_LO;
        else        state_s = LEN_HI;
      end
      LEN_LO: begin
        if (!xfer_s)                    state_s = LEN_LO;
        else if (len_full_s > MAX_WORDS) state_s = ERR;
        else if (len_full_s == 17'd0)    state_s = CSUM;
        else                             state_s = DATA;
      end
      DATA: begin
        if (xfer_s && last_word_s) state_s = CSUM;
        else                       state_s = DATA;
      end
      CSUM: begin
        if (!xfer_s)               state_s = CSUM;
        else if (rx_data == csum_r) state_s = DONE;
        else                        state_s = ERR;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and status outputs, decoded from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      rx_ready_r   <= 1'b0;
      core_reset_r <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      rx_ready_r   <= (state_s == LEN_HI) | (state_s == LEN_LO) | (state_s == DATA) | (state_s == CSUM);
      core_reset_r <= (state_s != DONE);
      done_r       <= (state_s == DONE);
      error_r      <= (state_s == ERR);
    end
  end

  // Header capture, word assembly, checksum accumulation and memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
      len_r        <= 16'd0;
      len_hi_r     <= 8'd0;
      csum_r       <= 8'd0;
      shift_r      <= 24'd0;
      byte_idx_r   <= 2'd0;
      word_idx_r   <= 16'd0;
    end else begin
      imem_we_r <= 1'b0;
      if (restart_s) begin
        csum_r     <= 8'd0;
        byte_idx_r <= 2'd0;
        word_idx_r <= 16'd0;
      end
      if (xfer_s) begin
        case (state_r)
          LEN_HI: len_hi_r <= rx_data;
          LEN_LO: len_r    <= {len_hi_r, rx_data};
          DATA: begin
            csum_r     <= csum_next(csum_r, rx_data);
            shift_r    <= {shift_r[15:0], rx_data};
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              imem_we_r    <= 1'b1;
              imem_addr_r  <= word_idx_r[ADDR_WIDTH-1:0];
              imem_wdata_r <= {shift_r, rx_data};
              word_idx_r   <= word_idx_r + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready   = rx_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign core_reset = core_reset_r;
  assign done       = done_r;
  assign error      = error_r;
  assign word_count = len_r;

endmodule
